apb_master_arbiter: RTL

//  - APB master controller sharing one APB bus between NUM_REQ requesters. Drives paddr/pwrite/pwdata/penable/pselx.
//  - Round-robin grant; sequences the SETUP/ACCESS phases and returns per-requester completion, read data and error.
//  - Sits between local requesters and the apb_dut slave; also absorbs hung slaves via an ACCESS timeout.

---
 rtl/apb_ctrl_pkg.sv | 15 +
 rtl/apb_rr_arbiter.sv | 62 ++++++
 rtl/apb_master_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/apb_ctrl_pkg.sv
// rtl/apb_ctrl_pkg.sv - shared types and default widths for the APB master arbiter
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - round-robin pick with registered rotation pointer
module apb_rr_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       update,
  input  logic [$clog2(NUM_REQ)-1:0] cur_idx,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_inc;
  logic [IDX_W-1:0] base;

  // Pointer that follows the completing grant; on a completion edge the search
  // already starts from it so back-to-back picks see the rotated order.
  always_comb begin
    ptr_inc = '0;
    if (int'(cur_idx) != NUM_REQ - 1) begin
      ptr_inc = cur_idx + 1'b1;
    end
    base = update ? ptr_inc : ptr_q;
  end

  // First requester at or after base, wrapping around.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(base) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!any && req[idx[IDX_W-1:0]]) begin
        any                  = 1'b1;
        gnt_idx              = idx[IDX_W-1:0];
        gnt[idx[IDX_W-1:0]]  = 1'b1;
      end
    end
  end

  // Rotation pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (update) begin
      ptr_q <= ptr_inc;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - APB master sharing one bus between several requesters
module apb_master_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  output logic                      penable,
  output logic                      pselx,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslave_error
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  apb_state_e state;
  apb_state_e state_d;

  logic [IDX_W-1:0]   g_idx;
  logic [NUM_REQ-1:0] g_onehot;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               arb_update;
  logic               load;
  logic               done;
  logic               timeout_hit;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (pclk),
    .rst     (preset),
    .req     (arb_req),
    .update  (arb_update),
    .cur_idx (g_idx),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // Completion detection: slave ready, or the access has run its full budget.
  always_comb begin
    timeout_hit = (TIMEOUT != 0) && !pready && (cnt == CNT_LAST);
    done        = (state == ACCESS) && (pready || timeout_hit);
  end

  // FSM state register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state and arbitration strobes; the completing requester is masked.
  always_comb begin
    state_d    = state;
    arb_req    = '0;
    arb_update = 1'b0;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        arb_req = req_valid;
        if (arb_any) begin
          load    = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (done) begin
          arb_update = 1'b1;
          arb_req    = req_valid & ~g_onehot;
          if (arb_any) begin
            load    = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus outputs, request latch, timeout counter and response registers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      g_idx     <= '0;
      g_onehot  <= '0;
      cnt       <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pselx     <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      pselx     <= (state_d != IDLE);
      penable   <= (state_d == ACCESS);
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;

      if (load) begin
        g_idx    <= arb_idx;
        g_onehot <= arb_gnt;
        paddr    <= req_addr[arb_idx*ADDR_W +: ADDR_W];
        pwrite   <= req_write[arb_idx];
        pwdata   <= req_write[arb_idx] ? req_wdata[arb_idx*DATA_W +: DATA_W] : '0;
      end

      if (state == ACCESS && !done) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end

      if (done) begin
        rsp_valid <= g_onehot;
        rsp_err   <= pready ? pslave_error : 1'b1;
        rsp_rdata <= (pready && !pwrite) ? prdata : '0;
      end
    end
  end

  // The granted requester must hold its request unchanged until its response.
  logic req_stable;
  always_comb begin
    req_stable = req_valid[g_idx]
              && (req_addr[g_idx*ADDR_W +: ADDR_W] == paddr)
              && (req_write[g_idx] == pwrite)
              && (!pwrite || (req_wdata[g_idx*DATA_W +: DATA_W] == pwdata));
  end

  a_req_stable: assert property (@(posedge pclk) disable iff (preset)
    (state != IDLE) |-> req_stable);

endmodule
